parity_frame_tx: RTL and testbench

Controller that sequences even-parity generation for a stream of data words and serializes each word as a framed bit stream.
- Frame, LSB first: start bit (0), DATA_W data bits, one parity bit, stop bit (1).
- Upstream supplies words over a valid/ready handshake.
- The block sits between a parallel word source and a single-wire serial link, with a fixed bit period.

---
 rtl/parity_tx_pkg.sv | 21 ++
 rtl/parity_frame_tx_parity_calc.sv | 20 ++
 rtl/parity_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_parity_frame_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
// parity_tx_pkg
// Shared types and line levels for the parity frame transmitter.
//   state_e     : frame sequencer states (3-bit encoding)
//   TX_IDLE_LVL : serial line level between frames
//   START_LVL   : start bit level
//   STOP_LVL    : stop bit level
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;

endpackage

// File: rtl/parity_frame_tx_parity_calc.sv
// parity_calc
// Combinational parity of one data word.
// Build option: PARITY_ODD_EN selects odd parity; even parity when undefined.
// Ports:
//   data   (in,  DATA_W) : word to protect
//   parity (out, 1)      : bit that makes data+parity even (or odd) in 1s
module parity_calc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

`ifdef PARITY_ODD_EN
  assign parity = ~(^data);
`else
  assign parity = ^data;
`endif

endmodule

// File: rtl/parity_frame_tx.sv
// parity_frame_tx
// Accepts words over valid/ready and serializes each one LSB first as
// start(0), DATA_W data bits, parity, stop(1), every bit CLKS_PER_BIT cycles.
// Build option: PARITY_ODD_EN (odd parity, handled in parity_calc).
// Ports:
//   clk        (in)          : system clock, rising edge
//   rst        (in)          : synchronous active-high reset
//   in_data    (in, DATA_W)  : word to transmit
//   in_valid   (in)          : in_data is valid
//   in_ready   (out)         : word can be accepted (IDLE only)
//   tx         (out)         : serial line, idles high
//   parity_out (out)         : parity of the last captured word
//   busy       (out)         : frame in progress
//   done       (out)         : one-cycle pulse in the first IDLE cycle after a frame
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | driving the start bit
// DATA   | shifting data bits out, LSB first
// PARITY | driving the parity bit
// STOP   | driving the stop bit
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              parity_out,
  output logic              busy,
  output logic              done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     cyc_cnt_q, cyc_cnt_d;
  logic              tx_q, tx_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              parity_q, parity_d;
  logic              parity_w;
  logic              cyc_last;

  parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
    .data   (in_data),
    .parity (parity_w)
  );

  assign cyc_last = (cyc_cnt_q == CYC_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d   = START;
          shift_d   = in_data;
          parity_d  = parity_w;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end
      START: begin
        if (cyc_last) begin
          state_d   = DATA;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_last) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = PARITY;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cyc_last) begin
          state_d   = STOP;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_last) begin
          state_d   = IDLE;
          cyc_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        cyc_cnt_d = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      STOP:    tx_d = STOP_LVL;
      default: tx_d = TX_IDLE_LVL;
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      tx_q       <= TX_IDLE_LVL;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      parity_q   <= parity_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign tx         = tx_q;
  assign parity_out = parity_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

`ifdef PARITY_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct {
    int       id;
    logic [3:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data_a [2];
  logic [1:0] in_valid_a;
  logic [1:0] in_ready_w, tx_w, parity_w, busy_w, done_w;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: CLKS_PER_BIT=2 for framing tests; instance 1: CLKS_PER_BIT=1 for the sweep.
  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_w[0]), .tx(tx_w[0]), .parity_out(parity_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_w[1]), .tx(tx_w[1]), .parity_out(parity_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: pops an expected frame at every handshake and checks each bit,
  // the flags during the frame, the done cycle, and idle levels otherwise.
  task automatic mon(input int id);
    int   cpb = (id == 0) ? 2 : 1;
    bit   at_neg = 0;
    bit   from_done = 0;
    bit   aborted;
    bit   ok;
    exp_t e;
    logic [6:0] fb;
    forever begin
      if (!at_neg) @(negedge clk);
      at_neg = 0;
      if (rst) begin
        from_done = 0;
        continue;
      end
      if (in_valid_a[id] && in_ready_w[id]) begin
        ok = (exp_q.size() != 0) && (exp_q[0].id == id);
        chk($sformatf("sb_entry%0d", id), 32'(ok), 32'd1);
        from_done = 0;
        if (!ok) continue;
        e  = exp_q.pop_front();
        fb = {1'b1, e.par, e.data, 1'b0};
        @(posedge clk);
        aborted = 0;
        for (int i = 0; i < 7 * cpb; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (i == 0) chk($sformatf("parity_out%0d", id), 32'(parity_w[id]), 32'(e.par));
          if (i % cpb == 0)
            chk($sformatf("tx%0d_bit%0d", id, i / cpb), 32'(tx_w[id]), 32'(fb[i / cpb]));
          chk($sformatf("frame_flags%0d", id), {busy_w[id], done_w[id], in_ready_w[id]}, 32'b100);
        end
        if (aborted) begin
          @(posedge clk);
          @(negedge clk);
          chk($sformatf("rst_abort%0d", id),
              {tx_w[id], in_ready_w[id], busy_w[id], done_w[id], parity_w[id]}, 32'b11000);
          at_neg = 1;
          from_done = 1;
          continue;
        end
        @(negedge clk);
        chk($sformatf("done_cycle%0d", id),
            {done_w[id], in_ready_w[id], busy_w[id], tx_w[id]}, 32'b1101);
        at_neg = 1;
        from_done = 1;
        continue;
      end
      if (!from_done)
        chk($sformatf("idle%0d", id), {tx_w[id], in_ready_w[id], busy_w[id], done_w[id]}, 32'b1100);
      from_done = 0;
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic send(input int id, input logic [3:0] w, input logic p);
    exp_t e;
    bit   ok = 0;
    e.id = id; e.data = w; e.par = p ^ ODD;
    exp_q.push_back(e);
    in_data_a[id]  = w;
    in_valid_a[id] = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready_w[id]) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("accept_wait%0d", id), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int id);
    bit ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (done_w[id]) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("done_wait%0d", id), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] par_tab;
    par_tab       = 16'h6996;  // even parity of 0..15, bit i = parity(i)
    in_valid_a    = 2'b00;
    in_data_a[0]  = 4'h0;
    in_data_a[1]  = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (10) @(posedge clk);
    #1;

    // Single all-zero frame
    send(0, 4'b0000, 1'b0);
    in_valid_a[0] = 1'b0;
    wait_idle(0);

    // Back-to-back frames, second offered while first is in flight
    send(0, 4'b0111, 1'b1);
    send(0, 4'b1011, 1'b1);
    in_valid_a[0] = 1'b0;
    wait_idle(0);

    // in_valid held with changing data during the frame
    send(0, 4'b1010, 1'b0);
    for (int j = 0; j < 13; j++) begin
      in_data_a[0] = 4'(j * 5 + 3);
      @(posedge clk);
      #1;
    end
    in_valid_a[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of DATA
    send(0, 4'b0110, 1'b0);
    in_valid_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(0, 4'b1111, 1'b0);
    in_valid_a[0] = 1'b0;
    wait_idle(0);

    // Parity sweep at one cycle per bit
    for (int v = 0; v < 16; v++) begin
      send(1, 4'(v), par_tab[v]);
      in_valid_a[1] = 1'b0;
      wait_idle(1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
